// File: rtl/tdoa_collector_if.sv
// Bundle for the timer-side valid/ack capture and the downstream valid/ready frame output.
// The collector uses slave; the timers and downstream logic use master.
interface tdoa_collector_if #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned IDX_W  = 2
);
  logic [NUM_CH*32-1:0] ts_in;
  logic [NUM_CH-1:0]    ts_valid;
  logic [NUM_CH-1:0]    ts_ack;
  logic [NUM_CH*32-1:0] out_delta;
  logic [NUM_CH-1:0]    out_mask;
  logic [IDX_W-1:0]     out_ref;
  logic                 out_timeout;
  logic                 out_valid;
  logic                 out_ready;

  modport slave (
    input  ts_in, ts_valid, out_ready,
    output ts_ack, out_delta, out_mask, out_ref, out_timeout, out_valid
  );

  modport master (
    output ts_in, ts_valid, out_ready,
    input  ts_ack, out_delta, out_mask, out_ref, out_timeout, out_valid
  );
endinterface

// File: rtl/tdoa_collector.sv
// Collects one timestamp per microphone channel into a frame and emits signed
// arrival-time differences against the earliest-captured reference channel.
module tdoa_collector #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned WINDOW = 50000,
  parameter int unsigned IDX_W  = 2
) (
  input  logic            clk,
  input  logic            rst,
  tdoa_collector_if.slave bus
);
  localparam int unsigned TS_W  = 32;
  localparam int unsigned CNT_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    CALC    = 2'd2,
    OUT     = 2'd3
  } state_e;

  state_e                      state_q, state_d;
  logic [NUM_CH-1:0]           captured_q, captured_d;
  logic [NUM_CH-1:0]           ack_q, ack_d;
  logic [NUM_CH-1:0]           mask_q, mask_d;
  logic [NUM_CH-1:0][TS_W-1:0] ts_reg_q, ts_reg_d;
  logic [NUM_CH-1:0][TS_W-1:0] delta_q, delta_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic [IDX_W-1:0]            ref_q, ref_d;
  logic                        timeout_pend_q, timeout_pend_d;
  logic                        timeout_q, timeout_d;
  logic                        valid_q, valid_d;

  logic [NUM_CH-1:0]           cap_now;
  logic [IDX_W-1:0]            first_idx;
  logic                        all_cap;

  // Capture, reference pick and frame sequencing
  always_comb begin
    state_d        = state_q;
    captured_d     = captured_q;
    ts_reg_d       = ts_reg_q;
    delta_d        = delta_q;
    mask_d         = mask_q;
    cnt_d          = cnt_q;
    ref_d          = ref_q;
    timeout_pend_d = timeout_pend_q;
    timeout_d      = timeout_q;
    valid_d        = valid_q;
    cap_now        = '0;
    first_idx      = '0;

    if (state_q == IDLE || state_q == COLLECT) begin
      cap_now = bus.ts_valid & ~captured_q;
    end
    // Descending scan so the lowest captured index wins
    for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
      if (cap_now[i]) first_idx = IDX_W'(i);
    end
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (cap_now[i]) ts_reg_d[i] = bus.ts_in[TS_W*i +: TS_W];
    end
    ack_d      = cap_now;
    captured_d = captured_q | cap_now;
    all_cap    = &captured_d;

    case (state_q)
      IDLE: begin
        if (|cap_now) begin
          ref_d          = first_idx;
          cnt_d          = '0;
          timeout_pend_d = 1'b0;
          state_d        = all_cap ? CALC : COLLECT;
        end
      end
      COLLECT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (all_cap) begin
          timeout_pend_d = 1'b0;
          state_d        = CALC;
        end else if (cnt_q == CNT_W'(WINDOW - 1)) begin
          timeout_pend_d = 1'b1;
          state_d        = CALC;
        end
      end
      CALC: begin
        for (int unsigned i = 0; i < NUM_CH; i++) begin
          delta_d[i] = captured_q[i] ? (ts_reg_q[i] - ts_reg_q[ref_q]) : '0;
        end
        mask_d    = captured_q;
        timeout_d = timeout_pend_q;
        valid_d   = 1'b1;
        state_d   = OUT;
      end
      OUT: begin
        if (bus.out_ready) begin
          valid_d    = 1'b0;
          captured_d = '0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      captured_q     <= '0;
      ack_q          <= '0;
      mask_q         <= '0;
      ts_reg_q       <= '0;
      delta_q        <= '0;
      cnt_q          <= '0;
      ref_q          <= '0;
      timeout_pend_q <= 1'b0;
      timeout_q      <= 1'b0;
      valid_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      captured_q     <= captured_d;
      ack_q          <= ack_d;
      mask_q         <= mask_d;
      ts_reg_q       <= ts_reg_d;
      delta_q        <= delta_d;
      cnt_q          <= cnt_d;
      ref_q          <= ref_d;
      timeout_pend_q <= timeout_pend_d;
      timeout_q      <= timeout_d;
      valid_q        <= valid_d;
    end
  end

  assign bus.ts_ack      = ack_q;
  assign bus.out_delta   = delta_q;
  assign bus.out_mask    = mask_q;
  assign bus.out_ref     = ref_q;
  assign bus.out_timeout = timeout_q;
  assign bus.out_valid   = valid_q;
endmodule

// File: tb/tb_tdoa_collector.sv
// Directed bench for tdoa_collector: main 4-channel instance, short-window
// instance for window expiry and a 2-channel instance for wrap-around.
module tb_tdoa_collector;
  logic clk;
  logic rst;
  int   total;
  int   bad;

  tdoa_collector_if #(.NUM_CH(4), .IDX_W(2)) m_if ();
  tdoa_collector_if #(.NUM_CH(4), .IDX_W(2)) t_if ();
  tdoa_collector_if #(.NUM_CH(2), .IDX_W(1)) w_if ();

  tdoa_collector #(.NUM_CH(4), .WINDOW(50000), .IDX_W(2)) u_main (.clk(clk), .rst(rst), .bus(m_if.slave));
  tdoa_collector #(.NUM_CH(4), .WINDOW(16),    .IDX_W(2)) u_to   (.clk(clk), .rst(rst), .bus(t_if.slave));
  tdoa_collector #(.NUM_CH(2), .WINDOW(50000), .IDX_W(1)) u_wr   (.clk(clk), .rst(rst), .bus(w_if.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic set_ch(input int ch, input logic [31:0] v);
    m_if.ts_in[32*ch +: 32] = v;
    m_if.ts_valid[ch]       = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (m_if.out_valid !== 1'b0 || t_if.out_valid !== 1'b0 || w_if.out_valid !== 1'b0) begin
      bad++; $display("FAIL rst_valid got=%b%b%b exp=000", m_if.out_valid, t_if.out_valid, w_if.out_valid); end
    total++; if (m_if.ts_ack !== 4'b0 || m_if.out_mask !== 4'b0 || m_if.out_ref !== 2'd0 || m_if.out_timeout !== 1'b0) begin
      bad++; $display("FAIL rst_fields got=ack%b mask%b ref%0d to%b exp=0", m_if.ts_ack, m_if.out_mask, m_if.out_ref, m_if.out_timeout); end
    total++; if (m_if.out_delta !== 128'd0) begin
      bad++; $display("FAIL rst_delta got=%h exp=0", m_if.out_delta); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_all_ch();
    m_if.out_ready = 1'b1;
    set_ch(0, 32'd100); set_ch(1, 32'd130); set_ch(2, 32'd90); set_ch(3, 32'd100);
    @(negedge clk);
    total++; if (m_if.ts_ack !== 4'b1111) begin bad++; $display("FAIL all_ack got=%b exp=1111", m_if.ts_ack); end
    total++; if (m_if.out_valid !== 1'b0) begin bad++; $display("FAIL all_early_valid got=%b exp=0", m_if.out_valid); end
    m_if.ts_valid = '0;
    @(negedge clk);
    total++; if (m_if.ts_ack !== 4'b0000) begin bad++; $display("FAIL all_ack_pulse got=%b exp=0000", m_if.ts_ack); end
    total++; if (m_if.out_valid !== 1'b1) begin bad++; $display("FAIL all_valid got=%b exp=1", m_if.out_valid); end
    total++; if (m_if.out_delta !== {32'd0, 32'hFFFF_FFF6, 32'd30, 32'd0}) begin
      bad++; $display("FAIL all_delta got=%h exp=%h", m_if.out_delta, {32'd0, 32'hFFFF_FFF6, 32'd30, 32'd0}); end
    total++; if (m_if.out_ref !== 2'd0 || m_if.out_mask !== 4'b1111 || m_if.out_timeout !== 1'b0) begin
      bad++; $display("FAIL all_fields got=ref%0d mask%b to%b exp=ref0 mask1111 to0", m_if.out_ref, m_if.out_mask, m_if.out_timeout); end
    @(negedge clk);
    total++; if (m_if.out_valid !== 1'b0) begin bad++; $display("FAIL all_accept got=%b exp=0", m_if.out_valid); end
  endtask

  task automatic test_staggered();
    int          chs[4]  = '{2, 0, 3, 1};
    logic [31:0] vals[4] = '{32'd500, 32'd520, 32'd505, 32'd540};
    int          gaps[4] = '{0, 4, 6, 5};
    logic [3:0]  e;
    m_if.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      repeat (gaps[k]) @(negedge clk);
      set_ch(chs[k], vals[k]);
      @(negedge clk);
      e = 4'b0001 << chs[k];
      total++; if (m_if.ts_ack !== e) begin bad++; $display("FAIL stag_ack%0d got=%b exp=%b", k, m_if.ts_ack, e); end
      m_if.ts_valid = '0;
    end
    total++; if (m_if.out_valid !== 1'b0) begin bad++; $display("FAIL stag_early got=%b exp=0", m_if.out_valid); end
    @(negedge clk);
    total++; if (m_if.out_valid !== 1'b1 || m_if.out_ref !== 2'd2 || m_if.out_mask !== 4'b1111 || m_if.out_timeout !== 1'b0) begin
      bad++; $display("FAIL stag_fields got=v%b ref%0d mask%b to%b exp=v1 ref2 mask1111 to0", m_if.out_valid, m_if.out_ref, m_if.out_mask, m_if.out_timeout); end
    total++; if (m_if.out_delta !== {32'd5, 32'd0, 32'd40, 32'd20}) begin
      bad++; $display("FAIL stag_delta got=%h exp=%h", m_if.out_delta, {32'd5, 32'd0, 32'd40, 32'd20}); end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    logic [127:0] e0;
    logic [127:0] e1;
    e0 = {32'd30, 32'd20, 32'd10, 32'd0};
    e1 = {32'd25, 32'd24, 32'd23, 32'd0};
    m_if.out_ready = 1'b0;
    set_ch(0, 32'd10); set_ch(1, 32'd20); set_ch(2, 32'd30); set_ch(3, 32'd40);
    @(negedge clk);
    m_if.ts_valid = '0;
    @(negedge clk);
    set_ch(0, 32'd77);
    for (int c = 0; c < 10; c++) begin
      total++; if (m_if.out_valid !== 1'b1 || m_if.out_delta !== e0 || m_if.out_mask !== 4'b1111 || m_if.ts_ack !== 4'b0) begin
        bad++; $display("FAIL hold%0d got=v%b d%h mask%b ack%b exp=v1 d%h mask1111 ack0000", c, m_if.out_valid, m_if.out_delta, m_if.out_mask, m_if.ts_ack, e0); end
      @(negedge clk);
    end
    m_if.out_ready = 1'b1;
    @(negedge clk);
    total++; if (m_if.out_valid !== 1'b0 || m_if.ts_ack !== 4'b0000) begin
      bad++; $display("FAIL bp_accept got=v%b ack%b exp=v0 ack0000", m_if.out_valid, m_if.ts_ack); end
    @(negedge clk);
    total++; if (m_if.ts_ack !== 4'b0001) begin bad++; $display("FAIL bp_recap got=%b exp=0001", m_if.ts_ack); end
    m_if.ts_valid = '0;
    set_ch(1, 32'd100); set_ch(2, 32'd101); set_ch(3, 32'd102);
    @(negedge clk);
    total++; if (m_if.ts_ack !== 4'b1110) begin bad++; $display("FAIL bp_ack2 got=%b exp=1110", m_if.ts_ack); end
    m_if.ts_valid = '0;
    @(negedge clk);
    total++; if (m_if.out_valid !== 1'b1 || m_if.out_delta !== e1 || m_if.out_ref !== 2'd0) begin
      bad++; $display("FAIL bp_frame2 got=v%b d%h ref%0d exp=v1 d%h ref0", m_if.out_valid, m_if.out_delta, m_if.out_ref, e1); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    m_if.out_ready = 1'b1;
    set_ch(0, 32'd1000); set_ch(1, 32'd1005);
    @(negedge clk);
    total++; if (m_if.ts_ack !== 4'b0011) begin bad++; $display("FAIL rm_ack got=%b exp=0011", m_if.ts_ack); end
    m_if.ts_valid = '0;
    @(negedge clk);
    rst = 1'b1;
    set_ch(2, 32'd50); set_ch(3, 32'd60);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total++; if (m_if.out_valid !== 1'b0 || m_if.ts_ack !== 4'b0 || m_if.out_mask !== 4'b0 || m_if.out_delta !== 128'd0) begin
        bad++; $display("FAIL rm_rst%0d got=v%b ack%b mask%b d%h exp=0", c, m_if.out_valid, m_if.ts_ack, m_if.out_mask, m_if.out_delta); end
    end
    rst = 1'b0;
    @(negedge clk);
    total++; if (m_if.ts_ack !== 4'b1100 || m_if.out_valid !== 1'b0) begin
      bad++; $display("FAIL rm_recap got=ack%b v%b exp=ack1100 v0", m_if.ts_ack, m_if.out_valid); end
    m_if.ts_valid = '0;
    set_ch(0, 32'd70); set_ch(1, 32'd80);
    @(negedge clk);
    total++; if (m_if.ts_ack !== 4'b0011) begin bad++; $display("FAIL rm_ack2 got=%b exp=0011", m_if.ts_ack); end
    m_if.ts_valid = '0;
    @(negedge clk);
    total++; if (m_if.out_valid !== 1'b1 || m_if.out_ref !== 2'd2 || m_if.out_delta !== {32'd10, 32'd0, 32'd30, 32'd20}) begin
      bad++; $display("FAIL rm_frame got=v%b ref%0d d%h exp=v1 ref2 d%h", m_if.out_valid, m_if.out_ref, m_if.out_delta, {32'd10, 32'd0, 32'd30, 32'd20}); end
    @(negedge clk);
  endtask

  task automatic test_timeout();
    t_if.out_ready       = 1'b1;
    t_if.ts_in[63:32]    = 32'd7;
    t_if.ts_in[127:96]   = 32'd4;
    t_if.ts_valid        = 4'b1010;
    @(negedge clk);
    total++; if (t_if.ts_ack !== 4'b1010) begin bad++; $display("FAIL to_ack got=%b exp=1010", t_if.ts_ack); end
    t_if.ts_valid = '0;
    repeat (16) @(negedge clk);
    total++; if (t_if.out_valid !== 1'b0) begin bad++; $display("FAIL to_early got=%b exp=0", t_if.out_valid); end
    @(negedge clk);
    total++; if (t_if.out_valid !== 1'b1 || t_if.out_mask !== 4'b1010 || t_if.out_timeout !== 1'b1 || t_if.out_ref !== 2'd1) begin
      bad++; $display("FAIL to_fields got=v%b mask%b to%b ref%0d exp=v1 mask1010 to1 ref1", t_if.out_valid, t_if.out_mask, t_if.out_timeout, t_if.out_ref); end
    total++; if (t_if.out_delta !== {32'hFFFF_FFFD, 32'd0, 32'd0, 32'd0}) begin
      bad++; $display("FAIL to_delta got=%h exp=%h", t_if.out_delta, {32'hFFFF_FFFD, 32'd0, 32'd0, 32'd0}); end
    @(negedge clk);
  endtask

  task automatic test_wrap();
    w_if.out_ready = 1'b1;
    w_if.ts_in     = {32'h0000_0010, 32'hFFFF_FFF0};
    w_if.ts_valid  = 2'b11;
    @(negedge clk);
    total++; if (w_if.ts_ack !== 2'b11) begin bad++; $display("FAIL wr_ack got=%b exp=11", w_if.ts_ack); end
    w_if.ts_valid = '0;
    @(negedge clk);
    total++; if (w_if.out_valid !== 1'b1 || w_if.out_delta !== {32'h0000_0020, 32'h0} || w_if.out_ref !== 1'b0 || w_if.out_mask !== 2'b11) begin
      bad++; $display("FAIL wr_frame got=v%b d%h ref%0d mask%b exp=v1 d%h ref0 mask11", w_if.out_valid, w_if.out_delta, w_if.out_ref, w_if.out_mask, {32'h0000_0020, 32'h0}); end
    @(negedge clk);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    m_if.ts_in = '0; m_if.ts_valid = '0; m_if.out_ready = 1'b0;
    t_if.ts_in = '0; t_if.ts_valid = '0; t_if.out_ready = 1'b0;
    w_if.ts_in = '0; w_if.ts_valid = '0; w_if.out_ready = 1'b0;
    test_reset();
    test_all_ch();
    test_staggered();
    test_backpressure();
    test_reset_mid();
    test_timeout();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
